// File: rtl/bram_rd_defs.sv
// Shared definitions for the BRAM result reader: FSM state encoding,
// BRAM read latency and the idle write-enable pattern.
package bram_rd_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam int         BRAM_RD_LAT = 1;
  localparam logic [3:0] BRAM_W_IDLE = 4'b0000;

endpackage

// File: rtl/bram_rd_fifo.sv
// Small power-of-two FIFO buffering BRAM read data ahead of the output stream.
// Push and pop may occur in the same cycle; count reflects registered occupancy.
module bram_rd_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  // Control: pointers and occupancy; natural wrap since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/bram_result_reader.sv
// Read-side BRAM master: fetches word_cnt words from base_addr and streams them
// on a valid/ready port. Define BRAM_RD_CHECKSUM_EN to add a running checksum output.
module bram_result_reader
  import bram_rd_defs::*;
#(
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic              busy,
  output logic              finish,
  output logic              R_req,
  output logic [ADDR_W-1:0] addr,
  input  logic [31:0]       R_data,
  output logic [3:0]        W_req,
  output logic [31:0]       W_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data
`ifdef BRAM_RD_CHECKSUM_EN
  ,output logic [31:0]      checksum
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int OW = CW + 1;

  rd_state_t               r_state;
  rd_state_t               w_state_nxt;
  logic [ADDR_W-1:0]       r_addr;
  logic [CNT_W-1:0]        r_left;
  logic [BRAM_RD_LAT-1:0]  r_inflight;

  logic                    w_accept;
  logic                    w_issue;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_empty;
  logic [CW-1:0]           w_count;
  logic [31:0]             w_fifo_data;
  logic [OW-1:0]           w_occ_eff;
  logic                    w_credit;
  logic                    w_drained;

  function automatic logic [OW-1:0] inflight_cnt(input logic [BRAM_RD_LAT-1:0] v);
    logic [OW-1:0] n;
    n = '0;
    for (int i = 0; i < BRAM_RD_LAT; i++) n = n + OW'(v[i]);
    return n;
  endfunction

  assign w_accept = (r_state == IDLE) && start;
  assign w_push   = r_inflight[BRAM_RD_LAT-1];
  assign w_pop    = !w_empty && out_ready;

  // A word popped this cycle frees its slot before any read issued now returns,
  // so the credit check uses post-pop occupancy to sustain one word per cycle.
  assign w_occ_eff = OW'(w_count) + inflight_cnt(r_inflight) - OW'(w_pop);
  assign w_credit  = (w_occ_eff < OW'(BUF_DEPTH));
  assign w_drained = (w_occ_eff == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (word_cnt == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        w_issue = w_credit;
        if (w_credit && (r_left == CNT_W'(1))) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_drained) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Issue stage: address/count registers and in-flight tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_left     <= '0;
      r_inflight <= '0;
    end else begin
      r_inflight <= BRAM_RD_LAT'({r_inflight, w_issue});
      if (w_accept) begin
        r_addr <= base_addr;
        r_left <= word_cnt;
      end else if (w_issue) begin
        r_addr <= r_addr + ADDR_W'(ADDR_STEP);
        r_left <= r_left - CNT_W'(1);
      end
    end
  end

  // Capture stage: read data lands in the buffer one cycle after its request
  bram_rd_fifo #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (R_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef BRAM_RD_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_checksum <= '0;
    else if (w_accept) r_checksum <= '0;
    else if (w_pop)    r_checksum <= r_checksum + w_fifo_data;
  end

  assign checksum = r_checksum;
`endif

  assign R_req     = w_issue;
  assign addr      = r_addr;
  assign W_req     = BRAM_W_IDLE;
  assign W_data    = '0;
  assign busy      = (r_state != IDLE);
  assign finish    = (r_state == DONE);
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_fifo_data;

endmodule

// File: tb/tb_bram_result_reader.sv
// Directed bench for bram_result_reader with a behavioural 1-cycle BRAM model.
// Define BRAM_RD_CHECKSUM_EN to include the checksum scenario.
module tb_bram_result_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_cnt = '0;
  logic        busy;
  logic        finish;
  logic        R_req;
  logic [31:0] addr;
  logic [31:0] R_data = '0;
  logic [3:0]  W_req;
  logic [31:0] W_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
`ifdef BRAM_RD_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] bram [0:1023];
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (R_req) R_data <= bram[addr[11:2]];
  end

  bram_result_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .finish    (finish),
    .R_req     (R_req),
    .addr      (addr),
    .R_data    (R_data),
    .W_req     (W_req),
    .W_data    (W_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BRAM_RD_CHECKSUM_EN
    ,.checksum (checksum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] b, input int k);
    logic [31:0] a;
    a = b + 32'(k) * 32'd4;
    return bram[a[11:2]];
  endfunction

  // Runs one transfer starting at the current cycle. rmode 0: ready held high,
  // 1: random ready. boff>0 pulses a competing start at that offset.
  // stop_after>0 returns right after observing that many transfers.
  task automatic stream(input logic [31:0] base, input int cnt, input int rmode,
                        input int boff, input int stop_after,
                        output int first_req, output int first_vld,
                        output int last_off, output int busy_cyc);
    int t0, nreq, nxfer, fin_cyc, occ_m, inf_m, budget, p;
    logic [31:0] prev_data;
    logic prev_stall, done, stopped;
    t0 = cyc; nreq = 0; nxfer = 0; fin_cyc = -1; occ_m = 0; inf_m = 0; budget = 0;
    first_req = -1; first_vld = -1; last_off = -1; busy_cyc = 0;
    prev_stall = 1'b0; prev_data = '0; done = 1'b0; stopped = 1'b0;
    start = 1'b1; base_addr = base; word_cnt = 16'(cnt);
    while (!done) begin
      if (cyc != t0) begin
        if (boff > 0 && cyc == t0 + boff) begin
          start = 1'b1; base_addr = 32'h100; word_cnt = 16'd3;
        end else begin
          start = 1'b0;
        end
      end
      out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      p = int'(out_valid && out_ready);
      if (R_req) begin
        if (first_req < 0) first_req = cyc - t0;
        chk("addr", addr, base + 32'(nreq) * 32'd4);
        chk("credit", 32'(occ_m - p + inf_m < 2), 32'd1);
        nreq++;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && first_vld < 0) first_vld = cyc - t0;
      if (p != 0) begin
        chk("data", out_data, exp_word(base, nxfer));
        nxfer++;
        last_off = cyc - t0;
      end
      if (busy) busy_cyc++;
      if (finish) begin
        fin_cyc = cyc;
        done = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      occ_m = occ_m + inf_m - p;
      inf_m = int'(R_req);
      if (stop_after > 0 && nxfer == stop_after) begin
        done = 1'b1; stopped = 1'b1;
      end
      budget++;
      if (!done && budget > 400) begin
        n_vec++; n_err++;
        $error("FAIL timeout: observed no finish after %0d cycles, expected finish", budget);
        done = 1'b1; stopped = 1'b1;
      end
      if (!done) tick();
    end
    start = 1'b0;
    if (!stopped) begin
      chk("n_req", 32'(nreq), 32'(cnt));
      chk("n_xfer", 32'(nxfer), 32'(cnt));
      chk("finish_cyc", 32'(fin_cyc), (cnt == 0) ? 32'(t0 + 1) : 32'(t0 + last_off + 1));
      tick();
      chk("busy_after", 32'(busy), 32'd0);
      chk("finish_after", 32'(finish), 32'd0);
    end
  endtask

  initial begin
    int fr, fv, lo, bc;
    for (int i = 0; i < 1024; i++) bram[i] = 32'hA500_0000 | 32'(i);
    for (int i = 0; i < 8; i++) bram[i] = 32'(i + 1);

    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_rreq", 32'(R_req), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("w_req", 32'(W_req), 32'd0);
    chk("w_data", W_data, 32'd0);
`ifdef BRAM_RD_CHECKSUM_EN
    chk("rst_checksum", checksum, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Basic: words 1..8, first R_req at +1, first valid at +3, last transfer at +10
    stream(32'h0, 8, 0, 0, 0, fr, fv, lo, bc);
    chk("basic_first_req", 32'(fr), 32'd1);
    chk("basic_first_vld", 32'(fv), 32'd3);
    chk("basic_last_xfer", 32'(lo), 32'd10);

    // Zero count: no reads, finish the cycle after start, busy for one cycle
    stream(32'h40, 0, 0, 0, 0, fr, fv, lo, bc);
    chk("zero_req", 32'(fr), 32'hFFFF_FFFF);
    chk("zero_busy_cyc", 32'(bc), 32'd1);

    // Backpressure with random ready
    stream(32'h80, 16, 1, 0, 0, fr, fv, lo, bc);

    // Start while busy is ignored
    stream(32'h0, 8, 0, 4, 0, fr, fv, lo, bc);
    chk("busy_start_last", 32'(lo), 32'd10);

    // Address wrap across 2^32
    stream(32'hFFFF_FFF8, 4, 0, 0, 0, fr, fv, lo, bc);

    // Reset after three transfers, then a fresh run from a new base
    stream(32'h40, 8, 0, 0, 3, fr, fv, lo, bc);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rreq", 32'(R_req), 32'd0);
    chk("mid_rst_addr", addr, 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_finish", 32'(finish), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stream(32'h200, 5, 1, 0, 0, fr, fv, lo, bc);

`ifdef BRAM_RD_CHECKSUM_EN
    for (int i = 0; i < 4; i++) bram[i] = 32'hFFFF_FFFF;
    stream(32'h0, 4, 0, 0, 0, fr, fv, lo, bc);
    chk("checksum", checksum, 32'hFFFF_FFFC);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
